// File: rtl/fir_axil_if.sv
// AXI-Lite write-address/write-data/read channels between the bus master and the FIR config block.
// There is no B channel: every write completes in its handshake cycle.
interface fir_axil_if #(
   parameter int pADDR_WIDTH = 12,
   parameter int pDATA_WIDTH = 32
);
   logic                   awvalid;
   logic                   awready;
   logic [pADDR_WIDTH-1:0] awaddr;
   logic                   wvalid;
   logic                   wready;
   logic [pDATA_WIDTH-1:0] wdata;
   logic                   arvalid;
   logic                   arready;
   logic [pADDR_WIDTH-1:0] araddr;
   logic                   rvalid;
   logic                   rready;
   logic [pDATA_WIDTH-1:0] rdata;

   modport master (
      output awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
      input  awready, wready, arready, rvalid, rdata
   );

   modport slave (
      input  awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
      output awready, wready, arready, rvalid, rdata
   );
endinterface

// File: rtl/fir_axil_cfg.sv
// AXI-Lite configuration responder for the FIR block: ap_ctrl, data_length and tap_num registers,
// plus tap RAM access that is handed over to the engine while a run is active.
//
// state   | meaning
// R_IDLE  | waiting for arvalid; arready is given combinationally
// R_ISSUE | tap RAM read issued (held here while a write handshake owns the RAM port)
// R_CAP   | tap_Do or register value captured into rdata
// R_DATA  | rvalid high, rdata held until rready
module fir_axil_cfg #(
   parameter int pADDR_WIDTH = 12,
   parameter int pDATA_WIDTH = 32
) (
   input  logic                   axis_clk,
   input  logic                   axis_rst_n,
   fir_axil_if.slave              axil,
   output logic [3:0]             tap_WE,
   output logic                   tap_EN,
   output logic [pDATA_WIDTH-1:0] tap_Di,
   output logic [pADDR_WIDTH-1:0] tap_A,
   input  logic [pDATA_WIDTH-1:0] tap_Do,
   input  logic                   eng_tap_EN,
   input  logic [pADDR_WIDTH-1:0] eng_tap_A,
   output logic                   ap_start,
   input  logic                   ap_done_in,
   output logic                   ap_idle,
   output logic [pDATA_WIDTH-1:0] data_length,
   output logic [pDATA_WIDTH-1:0] tap_num
);

   localparam logic [pADDR_WIDTH-1:0] ADDR_CTRL = pADDR_WIDTH'('h000);
   localparam logic [pADDR_WIDTH-1:0] ADDR_DLEN = pADDR_WIDTH'('h010);
   localparam logic [pADDR_WIDTH-1:0] ADDR_TNUM = pADDR_WIDTH'('h014);
   localparam logic [pADDR_WIDTH-1:0] TAP_BASE  = pADDR_WIDTH'('h080);
   localparam logic [pADDR_WIDTH-1:0] TAP_MASK  = pADDR_WIDTH'('h07F);

   typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_CAP, R_DATA} rd_state_t;

   rd_state_t              rd_state, rd_state_nx;
   logic [pADDR_WIDTH-1:0] rd_addr;
   logic                   rd_tap_go;
   logic                   rd_tap_hit;
   logic [pDATA_WIDTH-1:0] rdata_q;
   logic [pDATA_WIDTH-1:0] reg_rdata;
   logic                   ap_done;
   logic                   wr_hs;
   logic                   wr_tap;

   function automatic logic is_tap(input logic [pADDR_WIDTH-1:0] a);
      return (a & ~TAP_MASK) == TAP_BASE;
   endfunction

   assign wr_hs        = axis_rst_n & axil.awvalid & axil.wvalid;
   assign wr_tap       = wr_hs & is_tap(axil.awaddr);
   assign axil.awready = wr_hs;
   assign axil.wready  = wr_hs;
   assign axil.rdata   = rdata_q;

   // Tap RAM port owner: engine while busy, else a write handshake, else a pending read.
   always_comb begin
      tap_EN    = 1'b0;
      tap_WE    = 4'h0;
      tap_A     = '0;
      tap_Di    = '0;
      rd_tap_go = 1'b0;
      if (axis_rst_n) begin
         if (!ap_idle) begin
            tap_EN = eng_tap_EN;
            tap_A  = eng_tap_A;
         end else if (wr_tap) begin
            tap_EN = 1'b1;
            tap_WE = 4'hF;
            tap_A  = axil.awaddr & TAP_MASK;
            tap_Di = axil.wdata;
         end else if (rd_state == R_ISSUE && !wr_hs && is_tap(rd_addr)) begin
            tap_EN    = 1'b1;
            tap_A     = rd_addr & TAP_MASK;
            rd_tap_go = 1'b1;
         end
      end
   end

   always_comb begin
      rd_state_nx  = rd_state;
      axil.arready = 1'b0;
      axil.rvalid  = 1'b0;
      case (rd_state)
         R_IDLE: begin
            if (axis_rst_n && axil.arvalid) begin
               axil.arready = 1'b1;
               rd_state_nx  = R_ISSUE;
            end
         end
         R_ISSUE: if (!wr_hs) rd_state_nx = R_CAP;
         R_CAP:   rd_state_nx = R_DATA;
         R_DATA: begin
            axil.rvalid = 1'b1;
            if (axil.rready) rd_state_nx = R_IDLE;
         end
         default: rd_state_nx = R_IDLE;
      endcase
   end

   always_comb begin
      reg_rdata = '0;
      case (rd_addr)
         ADDR_CTRL: reg_rdata = pDATA_WIDTH'({ap_idle, ap_done, 1'b0});
         ADDR_DLEN: reg_rdata = data_length;
         ADDR_TNUM: reg_rdata = tap_num;
         default:   reg_rdata = '0;
      endcase
   end

   always_ff @(posedge axis_clk) begin
      if (!axis_rst_n) begin
         rd_state   <= R_IDLE;
         rd_addr    <= '0;
         rd_tap_hit <= 1'b0;
         rdata_q    <= '0;
      end else begin
         rd_state <= rd_state_nx;
         if (axil.arready) rd_addr <= axil.araddr;
         if (rd_state == R_ISSUE) rd_tap_hit <= rd_tap_go;
         // A tap read that never reached the RAM (engine owned it) answers all-ones.
         if (rd_state == R_CAP)
            rdata_q <= is_tap(rd_addr) ? (rd_tap_hit ? tap_Do : '1) : reg_rdata;
      end
   end

   always_ff @(posedge axis_clk) begin
      if (!axis_rst_n) begin
         ap_idle     <= 1'b1;
         ap_done     <= 1'b0;
         ap_start    <= 1'b0;
         data_length <= '0;
         tap_num     <= '0;
      end else begin
         ap_start <= 1'b0;
         if (ap_done_in) begin
            ap_done <= 1'b1;
            ap_idle <= 1'b1;
         end
         // Start sees the pre-edge idle, so a coincident done cannot enable it.
         if (wr_hs) begin
            case (axil.awaddr)
               ADDR_CTRL: begin
                  if (axil.wdata[0] && ap_idle) begin
                     ap_start <= 1'b1;
                     ap_idle  <= 1'b0;
                     ap_done  <= 1'b0;
                  end
               end
               ADDR_DLEN: data_length <= axil.wdata;
               ADDR_TNUM: tap_num     <= axil.wdata;
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fir_axil_cfg.sv
// Self-checking bench for fir_axil_cfg: directed scenarios plus random register/tap traffic,
// read data checked by a scoreboard against a behavioural model of the register space.
module tb_fir_axil_cfg;
   localparam int AW = 12;
   localparam int DW = 32;

   logic          axis_clk = 1'b0;
   logic          axis_rst_n = 1'b0;
   logic [3:0]    tap_WE;
   logic          tap_EN;
   logic [DW-1:0] tap_Di;
   logic [AW-1:0] tap_A;
   logic [DW-1:0] tap_Do;
   logic          eng_tap_EN;
   logic [AW-1:0] eng_tap_A;
   logic          ap_start;
   logic          ap_done_in;
   logic          ap_idle;
   logic [DW-1:0] data_length;
   logic [DW-1:0] tap_num;

   always #5 axis_clk = ~axis_clk;

   fir_axil_if #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW)) bus ();

   fir_axil_cfg #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW)) dut (
      .axis_clk    (axis_clk),
      .axis_rst_n  (axis_rst_n),
      .axil        (bus),
      .tap_WE      (tap_WE),
      .tap_EN      (tap_EN),
      .tap_Di      (tap_Di),
      .tap_A       (tap_A),
      .tap_Do      (tap_Do),
      .eng_tap_EN  (eng_tap_EN),
      .eng_tap_A   (eng_tap_A),
      .ap_start    (ap_start),
      .ap_done_in  (ap_done_in),
      .ap_idle     (ap_idle),
      .data_length (data_length),
      .tap_num     (tap_num)
   );

   // bram32 tap RAM, one-cycle read latency
   logic [31:0] ram [32];
   always @(posedge axis_clk) begin
      if (tap_EN) begin
         for (int b = 0; b < 4; b++)
            if (tap_WE[b]) ram[tap_A[6:2]][8*b +: 8] <= tap_Di[8*b +: 8];
         tap_Do <= ram[tap_A[6:2]];
      end
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // reference model of the register space
   logic [31:0] m_dl, m_tn;
   logic [31:0] m_taps [32];
   logic        m_idle, m_done;

   function automatic bit m_is_tap(input logic [11:0] a);
      return a >= 12'h080 && a <= 12'h0FF;
   endfunction

   function automatic logic [31:0] model_read(input logic [11:0] a);
      if (m_is_tap(a)) return m_idle ? m_taps[(a - 12'h080) / 4] : 32'hFFFF_FFFF;
      if (a == 12'h000) return {29'd0, m_idle, m_done, 1'b0};
      if (a == 12'h010) return m_dl;
      if (a == 12'h014) return m_tn;
      return 32'd0;
   endfunction

   task automatic model_write(input logic [11:0] a, input logic [31:0] d, input bit with_done);
      bit was_idle;
      was_idle = m_idle;
      if (with_done) begin
         m_done = 1'b1;
         m_idle = 1'b1;
      end
      if (m_is_tap(a) && was_idle) m_taps[(a - 12'h080) / 4] = d;
      if (a == 12'h000 && d[0] && was_idle) begin
         m_idle = 1'b0;
         m_done = 1'b0;
      end
      if (a == 12'h010) m_dl = d;
      if (a == 12'h014) m_tn = d;
   endtask

   task automatic model_reset();
      m_dl = 0; m_tn = 0; m_idle = 1'b1; m_done = 1'b0;
   endtask

   // scoreboard
   logic [31:0] exp_q  [$];
   logic [11:0] addr_q [$];

   always @(negedge axis_clk) begin : read_monitor
      logic [31:0] e;
      logic [11:0] a;
      if (axis_rst_n && bus.rvalid && bus.rready) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL rdata_unexpected: got rvalid with 0x%08h, required no read outstanding", bus.rdata);
         end else begin
            e = exp_q.pop_front();
            a = addr_q.pop_front();
            check($sformatf("rdata@%03h", a), bus.rdata, e);
         end
      end
   end

   // tap writes may only happen in a write handshake while idle
   always @(negedge axis_clk) begin
      if (tap_WE != 4'h0)
         check("tap_we_only_in_hs", {31'd0, bus.awvalid & bus.wvalid & ap_idle}, 32'd1);
   end

   task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input bit with_done);
      @(negedge axis_clk);
      bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.awaddr = a; bus.wdata = d;
      ap_done_in  = with_done;
      #1;
      check("awready", {31'd0, bus.awready}, 32'd1);
      if (m_is_tap(a) && m_idle) begin
         check("tap_wr_we", {28'd0, tap_WE}, 32'hF);
         check("tap_wr_a",  {20'd0, tap_A},  {20'd0, a - 12'h080});
         check("tap_wr_di", tap_Di, d);
      end else if (!m_idle) begin
         check("busy_wr_we", {28'd0, tap_WE}, 32'd0);
      end
      @(posedge axis_clk);
      model_write(a, d, with_done);
      #1;
      bus.awvalid = 1'b0; bus.wvalid = 1'b0; ap_done_in = 1'b0;
   endtask

   task automatic issue_ar(input logic [11:0] a);
      int t;
      t = 0;
      @(negedge axis_clk);
      bus.arvalid = 1'b1; bus.araddr = a;
      #1;
      while (!bus.arready && t < 20) begin
         @(negedge axis_clk);
         #1;
         t++;
      end
      if (t >= 20) check("arready_timeout", {31'd0, bus.arready}, 32'd1);
      @(posedge axis_clk);
      #1;
      bus.arvalid = 1'b0;
   endtask

   task automatic wait_drain();
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 50) begin
         @(posedge axis_clk);
         t++;
      end
      if (exp_q.size() != 0) begin
         check("read_timeout_outstanding", exp_q.size(), 32'd0);
         exp_q.delete();
         addr_q.delete();
      end
      @(posedge axis_clk);
      #1;
   endtask

   task automatic axi_read(input logic [11:0] a);
      int lat;
      exp_q.push_back(model_read(a));
      addr_q.push_back(a);
      issue_ar(a);
      lat = 0;
      do begin
         @(negedge axis_clk);
         lat++;
      end while (!bus.rvalid && lat < 10);
      check("read_latency", lat, 32'd3);
      wait_drain();
   endtask

   task automatic count_start(input string name, input int exp);
      int cnt;
      cnt = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge axis_clk);
         if (ap_start) cnt++;
      end
      check(name, cnt, exp);
   endtask

   logic [31:0] coef [31];
   logic [31:0] rnd_d;
   logic [11:0] rnd_a;
   logic [11:0] bad_addrs [7];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 32; i++) begin
         ram[i] = 32'd0;
         m_taps[i] = 32'd0;
      end
      bad_addrs = '{12'h004, 12'h008, 12'h00C, 12'h018, 12'h07C, 12'h100, 12'hFFC};
      coef[0] = 0; coef[1] = -10; coef[2] = -9; coef[3] = 23; coef[4] = 56; coef[5] = 63;
      coef[6] = 56; coef[7] = 23; coef[8] = -9; coef[9] = -10; coef[10] = 0;
      for (int k = 11; k < 31; k++) coef[k] = 32'(k * 7 - 100);
      bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 0; bus.rready = 1'b1;
      bus.awaddr = 0; bus.wdata = 0; bus.araddr = 0;
      eng_tap_EN = 0; eng_tap_A = 0; ap_done_in = 0;
      model_reset();

      // reset state
      repeat (3) @(posedge axis_clk);
      @(negedge axis_clk);
      check("rst_awready", {31'd0, bus.awready}, 32'd0);
      check("rst_arready", {31'd0, bus.arready}, 32'd0);
      check("rst_rvalid",  {31'd0, bus.rvalid},  32'd0);
      check("rst_rdata",   bus.rdata, 32'd0);
      check("rst_tap_en",  {31'd0, tap_EN}, 32'd0);
      check("rst_tap_we",  {28'd0, tap_WE}, 32'd0);
      check("rst_ap_start", {31'd0, ap_start}, 32'd0);
      check("rst_ap_idle", {31'd0, ap_idle}, 32'd1);
      check("rst_dlen",    data_length, 32'd0);
      check("rst_tnum",    tap_num, 32'd0);
      axis_rst_n = 1'b1;

      // 1: length / tap count registers
      axi_write(12'h010, 32'd600, 1'b0);
      axi_write(12'h014, 32'd31, 1'b0);
      axi_read(12'h010);
      axi_read(12'h014);
      check("dlen_port", data_length, 32'd600);
      check("tnum_port", tap_num, 32'd31);
      axi_read(12'h000);

      // 2: coefficients
      for (int k = 0; k < 31; k++) axi_write(12'(12'h080 + 4 * k), coef[k], 1'b0);
      for (int k = 0; k < 31; k++) axi_read(12'(12'h080 + 4 * k));

      // 3: start / done handshake
      axi_write(12'h000, 32'd1, 1'b0);
      count_start("ap_start_pulse", 1);
      check("ap_idle_after_start", {31'd0, ap_idle}, 32'd0);
      axi_read(12'h000);
      axi_write(12'h000, 32'd1, 1'b0);
      count_start("start_ignored_busy", 0);
      @(negedge axis_clk); ap_done_in = 1'b1;
      @(negedge axis_clk); ap_done_in = 1'b0;
      m_done = 1'b1; m_idle = 1'b1;
      axi_read(12'h000);

      // 4: busy behaviour
      axi_write(12'h000, 32'd1, 1'b0);
      count_start("ap_start_pulse2", 1);
      eng_tap_EN = 1'b1; eng_tap_A = 12'h008;
      @(negedge axis_clk);
      check("busy_tap_a",  {20'd0, tap_A}, 32'h008);
      check("busy_tap_en", {31'd0, tap_EN}, 32'd1);
      check("busy_tap_we", {28'd0, tap_WE}, 32'd0);
      axi_write(12'h084, 32'd7, 1'b0);
      axi_read(12'h084);
      axi_write(12'h010, 32'd1234, 1'b0);
      axi_read(12'h010);
      axi_write(12'h000, 32'd1, 1'b1);   // done and start together while busy
      count_start("done_start_busy", 0);
      eng_tap_EN = 1'b0; eng_tap_A = 12'h000;
      axi_read(12'h000);
      axi_read(12'h084);
      axi_write(12'h000, 32'd1, 1'b1);   // done and start together while idle
      count_start("done_start_idle", 1);
      axi_read(12'h000);
      @(negedge axis_clk); ap_done_in = 1'b1;
      @(negedge axis_clk); ap_done_in = 1'b0;
      m_done = 1'b1; m_idle = 1'b1;

      // 5: same-cycle tap write and read, late rready
      @(posedge axis_clk); #1 bus.rready = 1'b0;
      @(negedge axis_clk);
      bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.awaddr = 12'h088; bus.wdata = 32'd55;
      bus.arvalid = 1'b1; bus.araddr = 12'h088;
      model_write(12'h088, 32'd55, 1'b0);
      exp_q.push_back(model_read(12'h088));
      addr_q.push_back(12'h088);
      #1;
      check("same_cycle_arready", {31'd0, bus.arready}, 32'd1);
      check("same_cycle_awready", {31'd0, bus.awready}, 32'd1);
      @(posedge axis_clk);
      #1;
      bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
      begin
         int t;
         t = 0;
         do begin
            @(negedge axis_clk);
            t++;
         end while (!bus.rvalid && t < 10);
         check("same_cycle_latency", t, 32'd3);
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge axis_clk);
         check("rvalid_hold", {31'd0, bus.rvalid}, 32'd1);
         check("rdata_hold",  bus.rdata, 32'd55);
      end
      @(posedge axis_clk); #1 bus.rready = 1'b1;
      wait_drain();
      @(negedge axis_clk);
      check("rvalid_drop", {31'd0, bus.rvalid}, 32'd0);

      // random traffic while idle
      for (int n = 0; n < 80; n++) begin
         rnd_d = $urandom;
         case ($urandom_range(0, 5))
            0: rnd_a = ($urandom_range(0, 1) == 0) ? 12'h010 : 12'h014;
            1, 2: rnd_a = 12'(12'h080 + 4 * $urandom_range(0, 31));
            3: rnd_a = bad_addrs[$urandom_range(0, 6)];
            default: rnd_a = 12'h000;
         endcase
         if (rnd_a == 12'h000) axi_read(rnd_a);
         else if ($urandom_range(0, 1) == 0) axi_write(rnd_a, rnd_d, 1'b0);
         else axi_read(rnd_a);
      end

      // 6: reset while the read is capturing
      issue_ar(12'h010);
      @(negedge axis_clk);          // R_ISSUE
      @(negedge axis_clk);          // R_CAP
      axis_rst_n = 1'b0;
      @(posedge axis_clk);
      @(negedge axis_clk);
      check("rst_mid_tap_en", {31'd0, tap_EN}, 32'd0);
      axis_rst_n = 1'b1;
      model_reset();
      for (int i = 0; i < 5; i++) begin
         @(negedge axis_clk);
         check("rst_mid_no_rvalid", {31'd0, bus.rvalid}, 32'd0);
      end
      axi_read(12'h000);
      axi_read(12'h010);
      axi_read(12'h088);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
